// File: rtl/write_mems_pkg.sv
// Shared constants and types for the stub-memory writer.
package write_mems_pkg;

  localparam int DATA_W      = 36;
  localparam int NMEM        = 7;
  localparam int ADDR_W      = 6;
  localparam int MAX_ENTRIES = (1 << ADDR_W) - 1;

  // Per-memory entry counts, memory i at [i*ADDR_W +: ADDR_W].
  typedef logic [NMEM*ADDR_W-1:0] count_vec_t;

  // Fill state of the page currently being written.
  typedef enum logic {
    EMPTY   = 1'b0,
    FILLING = 1'b1
  } fill_state_t;

endpackage

// File: rtl/write_mems_wr_ptr_cnt.sv
// Write pointer for a single stub memory: next free address on the current page.
// Saturates at MAX_ENTRIES and never wraps. A clear starts a fresh page, and an
// increment in the same cycle lands at address 0 of that page.
module write_mems_wr_ptr_cnt
  import write_mems_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              full
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  assign ptr  = ptr_q;
  assign full = (ptr_q == ADDR_W'(MAX_ENTRIES));

  // Next pointer: restart on clear, else step while there is room.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = inc ? ADDR_W'(1) : '0;
    end else if (inc && !full) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/write_mems.sv
// Writer side of the stub-memory link. Routes one stub per cycle into the
// addressed memory at its next free slot, and at each event boundary
// publishes the closing page's entry counts and flips to the other page.
module write_mems
  import write_mems_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_W-1:0]      stub_in,
  input  logic                   stub_valid,
  input  logic [2:0]             stub_dest,
  output logic [NMEM-1:0]        wr_en,
  output logic [ADDR_W:0]        wr_add,
  output logic [DATA_W-1:0]      wr_data,
  output logic [NMEM*ADDR_W-1:0] number_out,
  output logic                   page_out,
  output logic                   done,
  output logic                   overflow
);

  logic              dest_ok;
  logic [NMEM-1:0]   sel;
  logic [NMEM-1:0]   full;
  logic [NMEM-1:0]   inc;
  logic [ADDR_W-1:0] ptr [NMEM];
  count_vec_t        ptr_vec;
  logic [ADDR_W-1:0] sel_ptr;
  logic              drop_full;

  logic [NMEM-1:0]   wr_en_q,    wr_en_d;
  logic [ADDR_W:0]   wr_add_q,   wr_add_d;
  logic [DATA_W-1:0] wr_data_q,  wr_data_d;
  count_vec_t        number_q,   number_d;
  logic              page_out_q, page_out_d;
  logic              done_q,     done_d;
  logic              overflow_q, overflow_d;
  logic              page_q,     page_d;
  fill_state_t       state_q,    state_d;

  // Out-of-range destinations are dropped without raising overflow.
  assign dest_ok = stub_valid && (stub_dest < 3'(NMEM));

  genvar gi;
  generate
    for (gi = 0; gi < NMEM; gi++) begin : g_mem
      assign sel[gi] = dest_ok && (stub_dest == 3'(gi));
      // On a boundary the pointer restarts at 0, so the memory cannot be full.
      assign inc[gi] = sel[gi] && (start || !full[gi]);
      assign ptr_vec[gi*ADDR_W +: ADDR_W] = ptr[gi];

      write_mems_wr_ptr_cnt u_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .inc   (inc[gi]),
        .ptr   (ptr[gi]),
        .full  (full[gi])
      );
    end
  endgenerate

  // Pointer of the addressed memory, and whether its stub is lost to a full page.
  always_comb begin
    sel_ptr = '0;
    for (int i = 0; i < NMEM; i++) begin
      if (sel[i]) sel_ptr = ptr[i];
    end
    drop_full = !start && |(sel & full);
  end

  // Write port, count publish, page toggle and sticky overflow.
  always_comb begin
    wr_en_d    = inc;
    wr_add_d   = wr_add_q;
    wr_data_d  = wr_data_q;
    number_d   = number_q;
    page_out_d = page_out_q;
    done_d     = 1'b0;
    page_d     = page_q;
    overflow_d = overflow_q | drop_full;
    if (|inc) begin
      wr_add_d  = start ? {~page_q, ADDR_W'(0)} : {page_q, sel_ptr};
      wr_data_d = stub_in;
    end
    if (start) begin
      number_d   = ptr_vec;
      page_out_d = page_q;
      done_d     = 1'b1;
      page_d     = ~page_q;
    end
  end

  // Page fill state: a boundary with no accepted stub leaves the new page empty.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (|inc) ? FILLING : EMPTY;
    end else if (|inc) begin
      state_d = FILLING;
    end
  end

  // Output and state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q    <= '0;
      wr_add_q   <= '0;
      wr_data_q  <= '0;
      number_q   <= '0;
      page_out_q <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      page_q     <= 1'b0;
      state_q    <= EMPTY;
    end else begin
      wr_en_q    <= wr_en_d;
      wr_add_q   <= wr_add_d;
      wr_data_q  <= wr_data_d;
      number_q   <= number_d;
      page_out_q <= page_out_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      page_q     <= page_d;
      state_q    <= state_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_add     = wr_add_q;
  assign wr_data    = wr_data_q;
  assign number_out = number_q;
  assign page_out   = page_out_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_write_mems.sv
// Directed bench for write_mems: expected writes go through a queue and are
// compared one cycle after the stimulus, alongside publish and overflow checks.
module tb_write_mems;
  import write_mems_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [DATA_W-1:0]      stub_in;
  logic                   stub_valid;
  logic [2:0]             stub_dest;
  logic [NMEM-1:0]        wr_en;
  logic [ADDR_W:0]        wr_add;
  logic [DATA_W-1:0]      wr_data;
  logic [NMEM*ADDR_W-1:0] number_out;
  logic                   page_out;
  logic                   done;
  logic                   overflow;

  write_mems dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stub_in    (stub_in),
    .stub_valid (stub_valid),
    .stub_dest  (stub_dest),
    .wr_en      (wr_en),
    .wr_add     (wr_add),
    .wr_data    (wr_data),
    .number_out (number_out),
    .page_out   (page_out),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NMEM-1:0]   en;
    logic [ADDR_W:0]   add;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t                    exp_q[$];
  int                     checks = 0;
  int                     errors = 0;
  int                     mptr[NMEM];
  logic                   mpage;
  logic                   movf;
  logic [ADDR_W:0]        last_add;
  logic [DATA_W-1:0]      last_data;
  logic [NMEM*ADDR_W-1:0] pub_num;
  logic                   pub_pg;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NMEM; i++) mptr[i] = 0;
    mpage = 1'b0; movf = 1'b0; last_add = '0; last_data = '0;
    pub_num = '0; pub_pg = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stub_valid = 1'b0; stub_dest = '0; stub_in = '0;
    @(posedge clk); #1;
    model_reset();
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_add", 64'(wr_add), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_number", 64'(number_out), 64'(0));
    chk("rst_page_out", 64'(page_out), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    $display("reset applied");
    reset = 1'b0;
  endtask

  // One clock of stimulus; the model predicts the write and any publish.
  task automatic step(input logic v, input logic [2:0] d, input logic [DATA_W-1:0] x, input logic s);
    wr_t e;
    stub_valid = v; stub_dest = d; stub_in = x; start = s;
    e.en = '0; e.add = last_add; e.data = last_data;
    if (s) begin
      for (int i = 0; i < NMEM; i++) begin
        pub_num[i*ADDR_W +: ADDR_W] = ADDR_W'(mptr[i]);
        mptr[i] = 0;
      end
      pub_pg = mpage;
      mpage  = ~mpage;
    end
    if (v && (int'(d) < NMEM)) begin
      if (mptr[d] < MAX_ENTRIES) begin
        e.en   = NMEM'(1) << d;
        e.add  = {mpage, ADDR_W'(mptr[d])};
        e.data = x;
        mptr[d]++;
      end else begin
        movf = 1'b1;
      end
    end
    last_add = e.add; last_data = e.data;
    exp_q.push_back(e);
    @(posedge clk); #1;
    stub_valid = 1'b0; start = 1'b0;
    e = exp_q.pop_front();
    chk("wr_en", 64'(wr_en), 64'(e.en));
    chk("wr_add", 64'(wr_add), 64'(e.add));
    chk("wr_data", 64'(wr_data), 64'(e.data));
    chk("done", 64'(done), 64'(s));
    chk("number_out", 64'(number_out), 64'(pub_num));
    chk("page_out", 64'(page_out), 64'(pub_pg));
    chk("overflow", 64'(overflow), 64'(movf));
    $display("t=%0t v=%0b dest=%0d start=%0b wr_en=%0h wr_add=%0h wr_data=%0h done=%0b number_out=%0h page_out=%0b ovf=%0b",
             $time, v, d, s, wr_en, wr_add, wr_data, done, number_out, page_out, overflow);
  endtask

  task automatic idle();
    step(1'b0, 3'd0, '0, 1'b0);
  endtask

  initial begin
    do_reset();

    // 1: three stubs to memory 2, then publish.
    step(1'b1, 3'd2, 36'hA, 1'b0);
    chk("t1_add0", 64'(wr_add), 64'h00);
    step(1'b1, 3'd2, 36'hB, 1'b0);
    step(1'b1, 3'd2, 36'hC, 1'b0);
    chk("t1_add2", 64'(wr_add), 64'h02);
    chk("t1_en", 64'(wr_en), 64'h04);
    idle();
    step(1'b0, 3'd0, '0, 1'b1);
    chk("t1_count2", 64'(number_out[2*ADDR_W +: ADDR_W]), 64'd3);
    chk("t1_page", 64'(page_out), 64'd0);

    // 2: fill memory 0 past capacity on page 1.
    for (int k = 0; k < 64; k++) step(1'b1, 3'd0, DATA_W'(k + 16'h100), 1'b0);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_last_add", 64'(wr_add), {57'd0, 1'b1, 6'd62});
    step(1'b0, 3'd0, '0, 1'b1);
    chk("t2_count0", 64'(number_out[0 +: ADDR_W]), 64'd63);

    // 3: stub arriving with the boundary lands on the new page.
    step(1'b1, 3'd5, 36'h55, 1'b1);
    chk("t3_add", 64'(wr_add), {57'd0, 1'b1, 6'd0});
    chk("t3_count5", 64'(number_out[5*ADDR_W +: ADDR_W]), 64'd0);
    idle();
    step(1'b0, 3'd0, '0, 1'b1);
    chk("t3_next_count5", 64'(number_out[5*ADDR_W +: ADDR_W]), 64'd1);
    chk("t3_page", 64'(page_out), 64'd1);

    // 4: out-of-range destination is ignored (overflow cleared by reset first).
    do_reset();
    step(1'b1, 3'd7, 36'h77, 1'b0);
    chk("t4_en", 64'(wr_en), 64'd0);
    chk("t4_ovf", 64'(overflow), 64'd0);

    // 5: back-to-back empty events.
    step(1'b0, 3'd0, '0, 1'b1);
    chk("t5_page_a", 64'(page_out), 64'd0);
    step(1'b0, 3'd0, '0, 1'b1);
    chk("t5_page_b", 64'(page_out), 64'd1);
    chk("t5_num", 64'(number_out), 64'd0);
    idle();

    // 6: reset mid-event discards partial counts.
    for (int k = 0; k < 5; k++) step(1'b1, 3'd1, DATA_W'(k + 16'h200), 1'b0);
    do_reset();
    step(1'b0, 3'd0, '0, 1'b1);
    chk("t6_count1", 64'(number_out[1*ADDR_W +: ADDR_W]), 64'd0);
    chk("t6_page", 64'(page_out), 64'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
